// File: rtl/tap_ctrl_param.sv
// Parametrised 1149.1 TAP controller: IR, BYPASS and USER data registers.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and reset opcode.
module tap_ctrl_param #(
  parameter int          IR_WIDTH      = 4,
  parameter int          NUM_USER_DR   = 2,
  parameter int          USER_DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001
) (
  input  logic                     GCLK_Pad,
  input  logic                     TRST_Pad,
  input  logic                     TMS_Pad,
  input  logic                     TDI_Pad,
  output logic                     TDO_Pad,
  output logic                     tdo_en,
  output logic [3:0]               state_obs_Pad,
  output logic [IR_WIDTH-1:0]      ir_out,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0] usr_capture_in,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0] usr_update_out,
  output logic [NUM_USER_DR-1:0]   usr_update_stb
);

  localparam int W  = USER_DR_WIDTH;
  localparam int DW = NUM_USER_DR * W;
  localparam int UW = (NUM_USER_DR > 1) ? $clog2(NUM_USER_DR) : 1;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_RESET  = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] OP_RESET  = '1;
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  if (IDCODE_VAL[0] != 1'b1 || IR_WIDTH < 2) begin : g_bad_cfg
    $error("tap_ctrl_param: IDCODE_VAL[0] must be 1, IR_WIDTH >= 2");
  end

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } state_t;

  state_t                state_q, state_d;
  logic                  tdo_en_q, tdo_en_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_sh_q, ir_sh_d;
  logic                  bp_q, bp_d;
  logic [W-1:0]          us_q, us_d;
  logic [DW-1:0]         upd_q, upd_d;
  logic [NUM_USER_DR-1:0] stb_q, stb_d;
`ifdef TAP_IDCODE_EN
  logic [31:0]           id_q, id_d;
  logic                  sel_id;
`endif

  logic                  sel_user;
  logic [UW-1:0]         user_idx;

  always_comb begin
    sel_user = 1'b0;
    user_idx = '0;
    for (int k = 0; k < NUM_USER_DR; k++) begin
      if (ir_q == IR_WIDTH'(k + 2)) begin
        sel_user = 1'b1;
        user_idx = UW'(k);
      end
    end
  end

`ifdef TAP_IDCODE_EN
  assign sel_id = (ir_q == OP_IDCODE);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS_Pad ? TLR    : RTI;
      RTI:    state_d = TMS_Pad ? SEL_DR : RTI;
      SEL_DR: state_d = TMS_Pad ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS_Pad ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS_Pad ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS_Pad ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS_Pad ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS_Pad ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS_Pad ? SEL_DR : RTI;
      SEL_IR: state_d = TMS_Pad ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS_Pad ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS_Pad ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS_Pad ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS_Pad ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS_Pad ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS_Pad ? SEL_DR : RTI;
    endcase
    tdo_en_d = (state_d == SH_DR) || (state_d == SH_IR);
  end

  always_comb begin
    ir_d    = ir_q;
    ir_sh_d = ir_sh_q;
    bp_d    = bp_q;
    us_d    = us_q;
    upd_d   = upd_q;
    stb_d   = '0;
`ifdef TAP_IDCODE_EN
    id_d    = id_q;
`endif
    unique case (state_q)
      TLR: ir_d = OP_RESET;
      CAP_IR: ir_sh_d = IR_CAPTURE;
      SH_IR: begin
        ir_sh_d = ir_sh_q >> 1;
        ir_sh_d[IR_WIDTH-1] = TDI_Pad;
      end
      UPD_IR: ir_d = ir_sh_q;
      CAP_DR: begin
        if (sel_user) begin
          for (int k = 0; k < NUM_USER_DR; k++) begin
            if (user_idx == UW'(k)) us_d = usr_capture_in[k*W +: W];
          end
        end
`ifdef TAP_IDCODE_EN
        else if (sel_id) id_d = IDCODE_VAL;
`endif
        else bp_d = 1'b0;
      end
      SH_DR: begin
        if (sel_user) begin
          us_d = us_q >> 1;
          us_d[W-1] = TDI_Pad;
        end
`ifdef TAP_IDCODE_EN
        else if (sel_id) id_d = {TDI_Pad, id_q[31:1]};
`endif
        else bp_d = TDI_Pad;
      end
      UPD_DR: begin
        for (int k = 0; k < NUM_USER_DR; k++) begin
          if (sel_user && user_idx == UW'(k)) begin
            upd_d[k*W +: W] = us_q;
            stb_d[k] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Only the serial path is combinational so TDO follows each shift edge.
  always_comb begin
    TDO_Pad = 1'b0;
    if (state_q == SH_IR) begin
      TDO_Pad = ir_sh_q[0];
    end else if (state_q == SH_DR) begin
      if (sel_user) TDO_Pad = us_q[0];
`ifdef TAP_IDCODE_EN
      else if (sel_id) TDO_Pad = id_q[0];
`endif
      else TDO_Pad = bp_q;
    end
  end

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      state_q  <= TLR;
      tdo_en_q <= 1'b0;
      ir_q     <= OP_RESET;
      ir_sh_q  <= '0;
      bp_q     <= 1'b0;
      us_q     <= '0;
      upd_q    <= '0;
      stb_q    <= '0;
`ifdef TAP_IDCODE_EN
      id_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tdo_en_q <= tdo_en_d;
      ir_q     <= ir_d;
      ir_sh_q  <= ir_sh_d;
      bp_q     <= bp_d;
      us_q     <= us_d;
      upd_q    <= upd_d;
      stb_q    <= stb_d;
`ifdef TAP_IDCODE_EN
      id_q     <= id_d;
`endif
    end
  end

  assign state_obs_Pad  = state_q;
  assign tdo_en         = tdo_en_q;
  assign ir_out         = ir_q;
  assign usr_update_out = upd_q;
  assign usr_update_stb = stb_q;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Randomised and directed bench for tap_ctrl_param against a queue model.
// Honours TAP_IDCODE_EN the same way as the design.
module tb_tap_ctrl_param;
  localparam int IRW = 4;
  localparam int NU  = 2;
  localparam int W   = 8;
  localparam int CW  = NU * W;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [IRW-1:0] RST_OP = 4'b0001;
`else
  localparam logic [IRW-1:0] RST_OP = 4'b1111;
`endif

  logic clk = 1'b0;
  logic trst, tms, tdi;
  logic tdo, en;
  logic [3:0] st;
  logic [IRW-1:0] ir;
  logic [CW-1:0] cap, upd;
  logic [NU-1:0] stb;

  always #5 clk = ~clk;

  tap_ctrl_param #(
    .IR_WIDTH(IRW), .NUM_USER_DR(NU),
    .USER_DR_WIDTH(W), .IDCODE_VAL(IDV)
  ) dut (
    .GCLK_Pad(clk), .TRST_Pad(trst),
    .TMS_Pad(tms), .TDI_Pad(tdi),
    .TDO_Pad(tdo), .tdo_en(en),
    .state_obs_Pad(st), .ir_out(ir),
    .usr_capture_in(cap),
    .usr_update_out(upd),
    .usr_update_stb(stb)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Model: state from the arc table, shift registers as bit FIFOs.
  int nxt[16][2];
  int m_st;
  logic [IRW-1:0] m_ir;
  logic [CW-1:0] m_upd;
  logic [NU-1:0] m_stb;
  bit drq[$];
  bit irq[$];

  task automatic arc(input int s, input int a0, input int a1);
    nxt[s][0] = a0;
    nxt[s][1] = a1;
  endtask

  function automatic int dr_sel(input logic [IRW-1:0] op);
    int v = int'(op);
    if (v == (1 << IRW) - 1) return -1;
`ifdef TAP_IDCODE_EN
    if (v == 1) return -2;
`endif
    if (v >= 2 && v < NU + 2) return v - 2;
    return -1;
  endfunction

  task automatic m_reset();
    m_st = 15;
    m_ir = RST_OP;
    m_upd = '0;
    m_stb = '0;
    drq.delete();
    irq.delete();
  endtask

  task automatic m_step(input logic t, input logic d,
                        input logic [CW-1:0] c);
    int s = m_st;
    int sel = dr_sel(m_ir);
    m_stb = '0;
    case (s)
      15: m_ir = RST_OP;
      14: begin
        irq.delete();
        for (int i = 0; i < IRW; i++) irq.push_back(i == 0);
      end
      10: begin
        void'(irq.pop_front());
        irq.push_back(d);
      end
      13: for (int i = 0; i < IRW; i++) m_ir[i] = irq[i];
      6: begin
        drq.delete();
        if (sel == -1) drq.push_back(1'b0);
        else if (sel == -2)
          for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
        else
          for (int i = 0; i < W; i++) drq.push_back(c[sel*W+i]);
      end
      2: begin
        void'(drq.pop_front());
        drq.push_back(d);
      end
      5: if (sel >= 0) begin
        for (int i = 0; i < W; i++) m_upd[sel*W+i] = drq[i];
        m_stb[sel] = 1'b1;
      end
      default: ;
    endcase
    m_st = nxt[s][t];
  endtask

  always @(posedge clk) if (!trst) m_step(tms, tdi, cap);

  function automatic logic m_tdo();
    if (m_st == 2 && drq.size() > 0) return drq[0];
    if (m_st == 10 && irq.size() > 0) return irq[0];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    chk("state", 64'(st), 64'(m_st));
    chk("tdo_en", 64'(en), 64'(m_st == 2 || m_st == 10));
    chk("tdo", 64'(tdo), 64'(m_tdo()));
    chk("ir_out", 64'(ir), 64'(m_ir));
    chk("upd_out", 64'(upd), 64'(m_upd));
    chk("upd_stb", 64'(stb), 64'(m_stb));
  end

  task automatic tick(input logic m, input logic d);
    @(negedge clk);
    #2;
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2;
    trst = 1'b1;
    m_reset();
    @(negedge clk);
    #2;
    trst = 1'b0;
  endtask

  task automatic to_rti();
    repeat (5) tick(1'b1, 1'($urandom));
    tick(1'b0, 1'b0);
  endtask

  task automatic ir_scan(input logic [IRW-1:0] c,
                         output logic [IRW-1:0] o);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) begin
      o[i] = tdo;
      tick(i == IRW - 1, c[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] d,
                         input int pause_at,
                         output logic [63:0] o);
    o = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      o[i] = tdo;
      if (i == pause_at) begin
        tick(1, d[i]);
        tick(0, 0);
        repeat (9) tick(0, 1'($urandom));
        tick(1, 0);
        tick(0, 0);
      end else begin
        tick(i == n - 1, d[i]);
      end
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  int wt[18] = '{0,1,0,0,1,0,1,1,1,1,0,1,0,1,0,1,1,0};
  int we[18] = '{12,7,6,2,1,3,0,5,7,4,14,9,11,8,10,9,13,12};

  initial begin
    logic [IRW-1:0] io;
    logic [63:0] o, d;
    arc(15, 12, 15); arc(12, 12, 7); arc(7, 6, 4);
    arc(4, 14, 15);  arc(6, 2, 1);   arc(2, 2, 1);
    arc(1, 3, 5);    arc(3, 3, 0);   arc(0, 2, 5);
    arc(5, 12, 7);   arc(14, 10, 9); arc(10, 10, 9);
    arc(9, 11, 13);  arc(11, 11, 8); arc(8, 10, 13);
    arc(13, 12, 7);
    trst = 1'b1; tms = 1'b1; tdi = 1'b0; cap = '0;
    m_reset();
    #1;
    chk("rst_state", 64'(st), 64'hF);
    chk("rst_ir", 64'(ir), 64'(RST_OP));
    chk("rst_upd", 64'({upd, stb, tdo, en}), 64'h0);
    @(negedge clk);
    #2 trst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      tick(wt[i][0], 1'b0);
      chk("walk", 64'(st), 64'(we[i]));
    end
    repeat (5) tick(1, 0);
    chk("five_ones", 64'(st), 64'hF);

    pulse_rst();
    chk("ir_after_rst", 64'(ir), 64'(RST_OP));
    tick(0, 0);
    d = 64'($urandom);
    dr_scan(32, d, -1, o);
`ifdef TAP_IDCODE_EN
    chk("idcode_out", o[31:0], 64'(IDV));
`else
    chk("bypass_rst", o[31:0], 64'({d[30:0], 1'b0}));
`endif

    ir_scan(4'b0111, io);
    chk("ir_capture", 64'(io), 64'h1);
    chk("ir_unused", 64'(ir), 64'h7);
    d = 64'($urandom);
    dr_scan(8, d, -1, o);
    chk("bypass_unused", o, 64'({d[6:0], 1'b0}));
    chk("bypass_nostb", 64'(stb), 64'h0);

    cap = {8'h77, 8'h3C};
    ir_scan(4'b0010, io);
    dr_scan(8, 64'hA5, -1, o);
    chk("user0_tdo", o, 64'h3C);
    chk("user0_upd", 64'(upd[7:0]), 64'hA5);
    chk("user0_stb", 64'(stb), 64'h1);
    tick(0, 0);
    chk("user0_stb_end", 64'(stb), 64'h0);

    cap = {8'h5A, 8'h11};
    ir_scan(4'b0011, io);
    dr_scan(8, 64'hC3, 3, o);
    chk("pause_tdo", o, 64'h5A);
    chk("pause_upd", 64'(upd), 64'hC3A5);
    chk("pause_stb", 64'(stb), 64'h2);

    ir_scan(4'b0010, io);
    tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (3) tick(0, 1);
    chk("mid_shdr", 64'(st), 64'h2);
    @(negedge clk);
    #2 trst = 1'b1;
    m_reset();
    #1;
    chk("trst_state", 64'(st), 64'hF);
    chk("trst_upd", 64'(upd), 64'h0);
    chk("trst_stb", 64'({stb, tdo}), 64'h0);
    @(negedge clk);
    #2 trst = 1'b0;
    repeat (3) begin
      tick(0, 0);
      chk("trst_nostb", 64'(stb), 64'h0);
    end

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_rst();
      if ($urandom_range(0, 59) == 0) begin
        to_rti();
        ir_scan(IRW'($urandom), io);
      end
      cap = CW'($urandom);
      tick($urandom_range(0, 2) == 0, 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
